// File: rtl/hdmi_rx_ceavid_seq_pkg.sv
// Shared definitions for the CEA video recovery sequencer and its register bank.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package hdmi_rx_ceavid_seq_pkg;

  // State encoding is visible in a status register, so the values are fixed.
  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 3'd0,
    ST_RST  = 3'd1,
    ST_WAIT = 3'd2,
    ST_RUN  = 3'd3,
    ST_HOLD = 3'd4
  } ceavid_st_t;

  // Health check for a running path. Any one of these conditions is a fault:
  // the fifo overflowed, alignment was lost, or the fifo ran dry while
  // video is still active.
  function automatic logic ceavid_fault(input logic fifo_full,
                                        input logic align_sts,
                                        input logic fifo_empty,
                                        input logic vid_sts);
    return fifo_full | ~align_sts | (fifo_empty & vid_sts);
  endfunction

endpackage

// File: rtl/hdmi_rx_ceavid_seq_sync2.sv
// Two-flop level synchroniser for a slow status bit crossing into ihdmiclk.
// Latency: 2 ihdmiclk cycles from a stable input to the output.
// Backpressure: none; level signal, no handshake.
//
// Ports:
//   ihdmiclk    destination clock
//   ihdmirst_n  asynchronous active-low reset, flops clear to 0
//   sync_clr    synchronous clear (block disabled), flops clear to 0
//   async_dat   level from the foreign clock domain
//   sync_dat    synchronised level
module hdmi_rx_sync2 (
  input  logic ihdmiclk,
  input  logic ihdmirst_n,
  input  logic sync_clr,
  input  logic async_dat,
  output logic sync_dat
);

  logic meta_dat;

  always_ff @(posedge ihdmiclk or negedge ihdmirst_n) begin
    if (!ihdmirst_n) begin
      meta_dat <= 1'b0;
      sync_dat <= 1'b0;
    end else if (sync_clr) begin
      meta_dat <= 1'b0;
      sync_dat <= 1'b0;
    end else begin
      meta_dat <= async_dat;
      sync_dat <= meta_dat;
    end
  end

endmodule

// File: rtl/hdmi_rx_ceavid_seq.sv
// Bring-up/recovery sequencer for the CEA video path: soft reset, wait for lock, watch health, retry.
// Latency: all outputs registered, 1 ihdmiclk cycle from inputs to outputs.
// Backpressure: none; status levels in, pulses and levels out, pulses are single-cycle.
//
// Ports:
//   ihdmiclk, ihdmirst_n  clock, asynchronous active-low reset
//   ihdmien               block enable; low clears everything synchronously
//   icfg_start            run level; low forces IDLE (highest priority)
//   icfg_auto_recover     on fault: 1 = HOLD then retry, 0 = back to IDLE
//   icfg_cnt_clr_p        clears both counters (wins over a coincident increment)
//   ialign_sts            alignment lock
//   ififo_full/empty      fifo status, only looked at in RUN
//   ivid_sts              video-active from the pixel clock domain
//   ocfg_ceavid_rst       soft reset to align/gen/fifo, high in IDLE and RST
//   ostate                current state (ST_IDLE..ST_HOLD)
//   olock_p/oerr_p/otimeout_p  lock, run-fault and wait-timeout events
//   oretry_cnt/oerr_cnt   saturating timeout / fault counters
module hdmi_rx_ceavid_seq
  import hdmi_rx_ceavid_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int ALIGN_TIMEOUT = 1000000,
  parameter int HOLD_CYCLES   = 256,
  parameter int TMR_W         = 20,
  parameter int CNT_W         = 8
) (
  input  logic             ihdmiclk,
  input  logic             ihdmirst_n,
  input  logic             ihdmien,
  input  logic             icfg_start,
  input  logic             icfg_auto_recover,
  input  logic             icfg_cnt_clr_p,
  input  logic             ialign_sts,
  input  logic             ififo_full,
  input  logic             ififo_empty,
  input  logic             ivid_sts,
  output logic             ocfg_ceavid_rst,
  output logic [ST_W-1:0]  ostate,
  output logic             olock_p,
  output logic             oerr_p,
  output logic             otimeout_p,
  output logic [CNT_W-1:0] oretry_cnt,
  output logic [CNT_W-1:0] oerr_cnt
);

  // Terminal timer values: the timer starts at 0 on state entry, so a state
  // that leaves at N-1 has been occupied for exactly N cycles.
  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(ALIGN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  ceavid_st_t       state;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_inc;
  logic             vid_sts_s;
  logic             fault;

  hdmi_rx_sync2 u_vid_sync (
    .ihdmiclk   (ihdmiclk),
    .ihdmirst_n (ihdmirst_n),
    .sync_clr   (~ihdmien),
    .async_dat  (ivid_sts),
    .sync_dat   (vid_sts_s)
  );

  assign tmr_inc = tmr + TMR_W'(1);
  assign fault   = ceavid_fault(ififo_full, ialign_sts, ififo_empty, vid_sts_s);
  assign ostate  = state;

  always_ff @(posedge ihdmiclk or negedge ihdmirst_n) begin
    if (!ihdmirst_n) begin
      state           <= ST_IDLE;
      tmr             <= '0;
      ocfg_ceavid_rst <= 1'b1;
      olock_p         <= 1'b0;
      oerr_p          <= 1'b0;
      otimeout_p      <= 1'b0;
      oretry_cnt      <= '0;
      oerr_cnt        <= '0;
    end else if (!ihdmien) begin
      state           <= ST_IDLE;
      tmr             <= '0;
      ocfg_ceavid_rst <= 1'b1;
      olock_p         <= 1'b0;
      oerr_p          <= 1'b0;
      otimeout_p      <= 1'b0;
      oretry_cnt      <= '0;
      oerr_cnt        <= '0;
    end else begin
      olock_p    <= 1'b0;
      oerr_p     <= 1'b0;
      otimeout_p <= 1'b0;
      // Timer is cleared unless a timed state stays put; this also covers
      // the "clear on every state change" rule.
      tmr        <= '0;

      if (!icfg_start) begin
        state           <= ST_IDLE;
        ocfg_ceavid_rst <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            state           <= ST_RST;
            ocfg_ceavid_rst <= 1'b1;
          end
          ST_RST: begin
            if (tmr == RST_LAST) begin
              state           <= ST_WAIT;
              ocfg_ceavid_rst <= 1'b0;
            end else begin
              tmr <= tmr_inc;
            end
          end
          ST_WAIT: begin
            // Lock is tested first so it beats a same-cycle timeout.
            if (ialign_sts) begin
              state   <= ST_RUN;
              olock_p <= 1'b1;
            end else if (tmr == WAIT_LAST) begin
              state           <= ST_RST;
              ocfg_ceavid_rst <= 1'b1;
              otimeout_p      <= 1'b1;
              if (oretry_cnt != CNT_MAX) oretry_cnt <= oretry_cnt + CNT_W'(1);
            end else begin
              tmr <= tmr_inc;
            end
          end
          ST_RUN: begin
            if (fault) begin
              oerr_p <= 1'b1;
              if (oerr_cnt != CNT_MAX) oerr_cnt <= oerr_cnt + CNT_W'(1);
              if (icfg_auto_recover) begin
                state <= ST_HOLD;
              end else begin
                state           <= ST_IDLE;
                ocfg_ceavid_rst <= 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (tmr == HOLD_LAST) begin
              state           <= ST_RST;
              ocfg_ceavid_rst <= 1'b1;
            end else begin
              tmr <= tmr_inc;
            end
          end
          default: begin
            state           <= ST_IDLE;
            ocfg_ceavid_rst <= 1'b1;
          end
        endcase
      end

      // Placed last so a clear overrides any increment issued above.
      if (icfg_cnt_clr_p) begin
        oretry_cnt <= '0;
        oerr_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_rx_ceavid_seq.sv
// Bench for hdmi_rx_ceavid_seq: directed table, corner-case sequences, random run vs reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_hdmi_rx_ceavid_seq;

  localparam int RST_C   = 16;
  localparam int TMO_C   = 100;
  localparam int HOLD_C  = 256;
  localparam int TMR_W   = 9;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, start = 1'b0, auto_r = 1'b0, clr = 1'b0;
  logic align = 1'b0, full = 1'b0, empty = 1'b0, vid = 1'b0;

  logic             cfg_rst;
  logic [2:0]       st;
  logic             lock_p, err_p, tmo_p;
  logic [CNT_W-1:0] rc, ec;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  hdmi_rx_ceavid_seq #(
    .RST_CYCLES    (RST_C),
    .ALIGN_TIMEOUT (TMO_C),
    .HOLD_CYCLES   (HOLD_C),
    .TMR_W         (TMR_W),
    .CNT_W         (CNT_W)
  ) dut (
    .ihdmiclk          (clk),
    .ihdmirst_n        (rst_n),
    .ihdmien           (en),
    .icfg_start        (start),
    .icfg_auto_recover (auto_r),
    .icfg_cnt_clr_p    (clr),
    .ialign_sts        (align),
    .ififo_full        (full),
    .ififo_empty       (empty),
    .ivid_sts          (vid),
    .ocfg_ceavid_rst   (cfg_rst),
    .ostate            (st),
    .olock_p           (lock_p),
    .oerr_p            (err_p),
    .otimeout_p        (tmo_p),
    .oretry_cnt        (rc),
    .oerr_cnt          (ec)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase-and-age view of the sequence: which phase we are in (0 idle,
  // 1 reset, 2 waiting, 3 running, 4 holding) and how many cycles we have
  // spent in it. The video status is seen through a two-deep delay line.
  int m_st = 0, m_age = 0, m_rc = 0, m_ec = 0;
  bit m_lock = 0, m_err = 0, m_tmo = 0;
  bit vid_dly[2] = '{0, 0};

  task automatic model_reset();
    m_st = 0; m_age = 0; m_rc = 0; m_ec = 0;
    m_lock = 0; m_err = 0; m_tmo = 0;
    vid_dly[0] = 0; vid_dly[1] = 0;
  endtask

  task automatic model_step();
    int  nxt;
    bit  lk, er, to, bad;
    nxt = m_st; lk = 0; er = 0; to = 0;
    bad = full || !align || (empty && vid_dly[1]);
    if (!start) nxt = 0;
    else if (m_st == 0) nxt = 1;
    else if (m_st == 1 && m_age + 1 == RST_C) nxt = 2;
    else if (m_st == 2 && align) begin nxt = 3; lk = 1; end
    else if (m_st == 2 && m_age + 1 == TMO_C) begin nxt = 1; to = 1; end
    else if (m_st == 3 && bad) begin er = 1; nxt = auto_r ? 4 : 0; end
    else if (m_st == 4 && m_age + 1 == HOLD_C) nxt = 1;
    if (clr) begin
      m_rc = 0; m_ec = 0;
    end else begin
      if (to) m_rc = (m_rc + 1 > CNT_MAX) ? CNT_MAX : m_rc + 1;
      if (er) m_ec = (m_ec + 1 > CNT_MAX) ? CNT_MAX : m_ec + 1;
    end
    m_age  = (nxt != m_st) ? 0 : m_age + 1;
    m_st   = nxt;
    m_lock = lk; m_err = er; m_tmo = to;
    vid_dly[1] = vid_dly[0];
    vid_dly[0] = vid;
  endtask

  always @(posedge clk) begin
    if (!rst_n || !en) model_reset();
    else model_step();
  end

  // Continuous scoreboard against the model, sampled away from the active edge.
  always @(negedge clk) begin
    chk("mdl_state",  st, m_st);
    chk("mdl_rst",    cfg_rst, (m_st <= 1));
    chk("mdl_pulses", {lock_p, err_p, tmo_p}, {m_lock, m_err, m_tmo});
    chk("mdl_cnts",   {rc, ec}, {m_rc[CNT_W-1:0], m_ec[CNT_W-1:0]});
  end

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic s, au, cl, al, fu, em, vi;
    logic [15:0] n;
    logic [2:0]  st;
    logic        r, lk, er, to;
    logic [1:0]  rc, ec;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic s, au, cl, al, fu, em, vi, input int n,
                              input logic [2:0] xs, input logic r, lk, er, to,
                              input logic [1:0] xrc, xec);
    vec_t v;
    v.s = s; v.au = au; v.cl = cl; v.al = al; v.fu = fu; v.em = em; v.vi = vi;
    v.n = 16'(n); v.st = xs; v.r = r; v.lk = lk; v.er = er; v.to = to;
    v.rc = xrc; v.ec = xec;
    return v;
  endfunction

  // Watchdog: the run is a few thousand cycles; this bound is far beyond it.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int p_cyc[8];
  int p_rc[8];
  int npulse;
  int rst_cnt;
  bit saw_wait;

  initial begin
    //            s au cl al fu em vi   n   st r lk er to rc ec
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,   2,  0, 1, 0, 0, 0, 0, 0); // idle
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0,   1,  1, 1, 0, 0, 0, 0, 0); // enter RST
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0,  15,  1, 1, 0, 0, 0, 0, 0); // 16th RST cycle
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0,   1,  2, 0, 0, 0, 0, 0, 0); // WAIT, rst drops
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0,   4,  2, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 1, 0, 0, 0,   1,  3, 0, 1, 0, 0, 0, 0); // lock
    tbl[6]  = mk(1, 1, 0, 1, 0, 1, 1,   2,  3, 0, 0, 0, 0, 0, 0); // vid still in sync
    tbl[7]  = mk(1, 1, 0, 1, 0, 1, 1,   1,  4, 0, 0, 1, 0, 0, 1); // empty&vid fault
    tbl[8]  = mk(1, 1, 0, 1, 0, 0, 0, 255,  4, 0, 0, 0, 0, 0, 1); // 256th HOLD cycle
    tbl[9]  = mk(1, 1, 0, 1, 0, 0, 0,   1,  1, 1, 0, 0, 0, 0, 1); // re-reset
    tbl[10] = mk(1, 1, 0, 1, 0, 0, 0,  16,  2, 0, 0, 0, 0, 0, 1);
    tbl[11] = mk(1, 1, 0, 1, 0, 0, 0,   1,  3, 0, 1, 0, 0, 0, 1);
    tbl[12] = mk(1, 1, 0, 1, 1, 0, 0,   1,  4, 0, 0, 1, 0, 0, 2); // full fault, auto
    tbl[13] = mk(1, 1, 0, 1, 0, 0, 0, 255,  4, 0, 0, 0, 0, 0, 2);
    tbl[14] = mk(1, 1, 0, 1, 0, 0, 0,   1,  1, 1, 0, 0, 0, 0, 2);
    tbl[15] = mk(1, 1, 0, 1, 0, 0, 0,  16,  2, 0, 0, 0, 0, 0, 2);
    tbl[16] = mk(1, 0, 0, 1, 0, 0, 0,   1,  3, 0, 1, 0, 0, 0, 2);
    tbl[17] = mk(1, 0, 1, 0, 0, 0, 0,   1,  0, 1, 0, 1, 0, 0, 0); // align loss, no auto, clr wins
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0,   3,  0, 1, 0, 0, 0, 0, 0);

    // ---- reset values ----
    repeat (3) @(negedge clk);
    chk("rst_state", st, 0);
    chk("rst_cfg_rst", cfg_rst, 1);
    chk("rst_pulses", {lock_p, err_p, tmo_p}, 0);
    chk("rst_cnts", {rc, ec}, 0);
    en = 1'b1;
    rst_n = 1'b1;

    // ---- directed table ----
    for (int i = 0; i < NV; i++) begin
      start = tbl[i].s;  auto_r = tbl[i].au; clr = tbl[i].cl; align = tbl[i].al;
      full  = tbl[i].fu; empty  = tbl[i].em; vid = tbl[i].vi;
      repeat (int'(tbl[i].n)) @(negedge clk);
      chk($sformatf("tbl%0d_state", i), st, tbl[i].st);
      chk($sformatf("tbl%0d_rst", i), cfg_rst, tbl[i].r);
      chk($sformatf("tbl%0d_lock", i), lock_p, tbl[i].lk);
      chk($sformatf("tbl%0d_err", i), err_p, tbl[i].er);
      chk($sformatf("tbl%0d_tmo", i), tmo_p, tbl[i].to);
      chk($sformatf("tbl%0d_retry", i), rc, tbl[i].rc);
      chk($sformatf("tbl%0d_errcnt", i), ec, tbl[i].ec);
    end

    // ---- repeated WAIT timeouts and retry saturation ----
    start = 1'b0; clr = 1'b1; align = 1'b0; auto_r = 1'b0;
    full = 1'b0; empty = 1'b0; vid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    start = 1'b1;
    npulse = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (tmo_p) begin
        if (npulse < 8) begin
          p_cyc[npulse] = c;
          p_rc[npulse]  = int'(rc);
        end
        npulse++;
      end
    end
    chk("tmo_count", npulse, 5);
    chk("tmo_first", p_cyc[0], RST_C + TMO_C + 1);
    for (int k = 1; k < 5; k++) chk($sformatf("tmo_period%0d", k), p_cyc[k] - p_cyc[k-1], RST_C + TMO_C);
    for (int k = 0; k < 5; k++) chk($sformatf("retry_at%0d", k), p_rc[k], (k + 1 > CNT_MAX) ? CNT_MAX : k + 1);

    // ---- start dropped mid-WAIT ----
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    repeat (RST_C + 4) @(negedge clk);
    chk("midwait_state", st, 2);
    start = 1'b0;
    @(negedge clk);
    chk("stop_state", st, 0);
    chk("stop_cfg_rst", cfg_rst, 1);
    chk("stop_pulses", {lock_p, err_p, tmo_p}, 0);

    // ---- asynchronous reset in the middle of RST ----
    start = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_arst_state", st, 1);
    chk("pre_arst_retry", rc, CNT_MAX);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", st, 0);
    chk("arst_cfg_rst", cfg_rst, 1);
    chk("arst_cnts", {rc, ec}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rst_cnt = 0;
    saw_wait = 0;
    for (int c = 0; c < 40 && !saw_wait; c++) begin
      @(negedge clk);
      if (st == 3'd1 && cfg_rst) rst_cnt++;
      if (st == 3'd2) saw_wait = 1;
    end
    chk("arst_reached_wait", saw_wait, 1);
    chk("arst_rst_cycles", rst_cnt, RST_C);

    // ---- randomized run against the model ----
    auto_r = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      en    = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 39) == 0) align = ~align;
      full  = ($urandom_range(0, 59) == 0);
      empty = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) vid = ~vid;
      clr   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 199) == 0) auto_r = ~auto_r;
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
